// File: rtl/kamacore_pkg.sv
// Shared constants and types for the kamacore memory subsystem.
// Used by the memory arbiter and its round-robin grant logic.
package kamacore_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int CPU_WIDTH  = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_RESP = 1'b1
   } arb_state_t;

   localparam int ARB_PORT_LSU    = 0;
   localparam int ARB_PORT_LOADER = 1;

endpackage

// File: rtl/kamacore_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from valid, priority pointer
// moves to the losing side whenever a grant is taken (advance=1).
module kamacore_rr_arbiter2
   import kamacore_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   // ptr_q names the port that wins when both request
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end

      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) begin
         ptr_d = grant[ARB_PORT_LSU];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'(ARB_PORT_LSU);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/kamacore_mem_arbiter.sv
// Shares the core memory read/write port between the LSU and the loader.
// Optional statistics counters are enabled by defining KAMACORE_ARB_STATS_EN.
module kamacore_mem_arbiter
   import kamacore_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
   parameter int RAM_SIZE       = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     req_valid,
   output logic [1:0]                     req_ready,
   input  logic [1:0]                     req_we,
   input  logic [1:0][MEM_ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0][CPU_WIDTH-1:0]      req_wdata,
   output logic [1:0]                     rsp_valid,
   input  logic [1:0]                     rsp_ready,
   output logic [CPU_WIDTH-1:0]           rsp_rdata,
   output logic                           rsp_err,
   output logic                           mem_we,
   output logic [MEM_ADDR_WIDTH-1:0]      mem_a,
   output logic [CPU_WIDTH-1:0]           mem_di,
   input  logic [CPU_WIDTH-1:0]           mem_spo
`ifdef KAMACORE_ARB_STATS_EN
   ,
   output logic [1:0][31:0]               stat_grants,
   output logic [31:0]                    stat_conflicts
`endif
);

   localparam logic [MEM_ADDR_WIDTH:0] RAM_LIMIT = (MEM_ADDR_WIDTH+1)'(RAM_SIZE);

   arb_state_t           state_q, state_d;
   logic [1:0]           rsp_valid_q, rsp_valid_d;
   logic [CPU_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;

   logic       idle;
   logic [1:0] arb_grant;
   logic [1:0] grant;
   logic       gnt_port;
   logic       gnt_in_range;

   // Grants only exist in IDLE and never while reset is asserted
   assign idle = (state_q == ARB_IDLE) && !rst;

   kamacore_rr_arbiter2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .valid   (req_valid),
      .advance (idle),
      .grant   (arb_grant)
   );

   assign grant     = idle ? arb_grant : 2'b00;
   assign req_ready = grant;

   always_comb begin
      gnt_port     = grant[ARB_PORT_LOADER];
      mem_a        = req_addr[gnt_port];
      mem_di       = req_wdata[gnt_port];
      gnt_in_range = ({1'b0, mem_a} < RAM_LIMIT);
      mem_we       = (grant != 2'b00) && req_we[gnt_port] && gnt_in_range;
   end

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (grant != 2'b00) begin
               state_d     = ARB_RESP;
               rsp_valid_d = grant;
               rsp_err_d   = !gnt_in_range;
               // Writes and rejected reads return zero rather than stale data
               rsp_rdata_d = (req_we[gnt_port] || !gnt_in_range) ? '0 : mem_spo;
            end
         end
         ARB_RESP: begin
            if ((rsp_valid_q & rsp_ready) != 2'b00) begin
               state_d     = ARB_IDLE;
               rsp_valid_d = 2'b00;
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            rsp_valid_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

`ifdef KAMACORE_ARB_STATS_EN
   logic [1:0][31:0] stat_grants_q, stat_grants_d;
   logic [31:0]      stat_conflicts_q, stat_conflicts_d;

   always_comb begin
      stat_grants_d    = stat_grants_q;
      stat_conflicts_d = stat_conflicts_q;
      if (grant != 2'b00) begin
         stat_grants_d[gnt_port] = stat_grants_q[gnt_port] + 32'd1;
         if (req_valid == 2'b11) begin
            stat_conflicts_d = stat_conflicts_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_grants_q    <= '0;
         stat_conflicts_q <= '0;
      end else begin
         stat_grants_q    <= stat_grants_d;
         stat_conflicts_q <= stat_conflicts_d;
      end
   end

   assign stat_grants    = stat_grants_q;
   assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Self-checking bench for kamacore_mem_arbiter: vector table, directed
// multi-cycle sequences and a randomized run against a transaction model.
module tb_kamacore_mem_arbiter;
   import kamacore_pkg::*;

   localparam int AW = ADDR_WIDTH;
   localparam int DW = CPU_WIDTH;
   localparam int RS = 1024;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0]            req_valid, req_ready, req_we;
   logic [1:0][AW-1:0]    req_addr;
   logic [1:0][DW-1:0]    req_wdata;
   logic [1:0]            rsp_valid, rsp_ready;
   logic [DW-1:0]         rsp_rdata;
   logic                  rsp_err;
   logic                  mem_we;
   logic [AW-1:0]         mem_a;
   logic [DW-1:0]         mem_di, mem_spo;

   logic [DW-1:0] tb_mem [RS] = '{default: '0};
   logic [DW-1:0] ref_mem [RS];

   int n_chk  = 0;
   int n_fail = 0;

   kamacore_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .RAM_SIZE(RS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_di    (mem_di),
      .mem_spo   (mem_spo)
   );

   always #5 clk = ~clk;

   // Memory: out-of-range reads return a recognisable non-zero pattern
   assign mem_spo = (mem_a < AW'(RS)) ? tb_mem[mem_a[9:0]] : 32'hA5A5_5A5A;
   always @(posedge clk) begin
      if (mem_we && (mem_a < AW'(RS))) tb_mem[mem_a[9:0]] <= mem_di;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_txn(input vec_t v);
      logic [1:0] oh;
      bit got;
      int k;
      oh = 2'b01 << v.port;
      tick();
      req_valid = oh;
      req_we[v.port] = v.we;
      req_addr[v.port] = v.addr;
      req_wdata[v.port] = v.wdata;
      rsp_ready = 2'b00;
      got = 0;
      k = 0;
      while (!got && k < 6) begin
         smp();
         if (req_ready != 2'b00) got = 1;
         else tick();
         k++;
      end
      chk("txn_grant", req_ready, oh);
      chk("txn_mem_we", mem_we, v.we && !v.exp_err);
      chk("txn_mem_a", mem_a, v.addr);
      tick();
      req_valid = 2'b00;
      smp();
      chk("txn_rsp_valid", rsp_valid, oh);
      chk("txn_rdata", rsp_rdata, v.exp_rdata);
      chk("txn_err", rsp_err, v.exp_err);
      chk("txn_resp_no_we", mem_we, 1'b0);
      rsp_ready = oh;
      tick();
      rsp_ready = 2'b00;
      smp();
      chk("txn_rsp_done", rsp_valid, 2'b00);
   endtask

   initial begin
      bit         m_resp;
      bit         m_pri;
      int         m_pend;
      logic [DW-1:0] m_rdata;
      logic       m_err;
      logic [1:0] exp_rdy;
      int         g;
      bit         inr;
      bit         got;
      int         k;

      vecs[0] = '{0, 1'b1, 12'd5,    32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[1] = '{0, 1'b0, 12'd5,    32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1, 1'b1, 12'd1023, 32'h1234_5678, 32'h0,         1'b0};
      vecs[3] = '{0, 1'b0, 12'd1023, 32'h0,         32'h1234_5678, 1'b0};
      vecs[4] = '{1, 1'b1, 12'd1024, 32'hCAFE_F00D, 32'h0,         1'b1};
      vecs[5] = '{1, 1'b0, 12'd1024, 32'h0,         32'h0,         1'b1};
      vecs[6] = '{1, 1'b1, 12'd0,    32'h0BAD_F00D, 32'h0,         1'b0};
      vecs[7] = '{0, 1'b0, 12'd0,    32'h0,         32'h0BAD_F00D, 1'b0};
      vecs[8] = '{1, 1'b0, 12'd5,    32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[9] = '{0, 1'b1, 12'd4095, 32'h7777_7777, 32'h0,         1'b1};

      // Reset with requests present, then idle
      rst = 1'b1;
      req_valid = 2'b11;
      req_we = 2'b11;
      req_addr[0] = 12'd3;
      req_addr[1] = 12'd3;
      req_wdata[0] = 32'h1;
      req_wdata[1] = 32'h2;
      rsp_ready = 2'b00;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("rst_req_ready", req_ready, 2'b00);
         chk("rst_mem_we", mem_we, 1'b0);
         chk("rst_rsp_valid", rsp_valid, 2'b00);
         chk("rst_rdata", rsp_rdata, 32'h0);
         chk("rst_err", rsp_err, 1'b0);
      end
      tick();
      rst = 1'b0;
      req_valid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("idle_req_ready", req_ready, 2'b00);
         chk("idle_mem_we", mem_we, 1'b0);
         chk("idle_rsp_valid", rsp_valid, 2'b00);
         tick();
      end

      for (int i = 0; i < 10; i++) do_txn(vecs[i]);

      // Backpressure: port 0 response held while port 1 waits
      tick();
      req_valid = 2'b01;
      req_we = 2'b00;
      req_addr[0] = 12'd5;
      req_addr[1] = 12'd1023;
      smp();
      chk("bp_grant0", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         smp();
         chk("bp_rsp_valid", rsp_valid, 2'b01);
         chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
         chk("bp_err", rsp_err, 1'b0);
         chk("bp_no_grant", req_ready, 2'b00);
         chk("bp_no_we", mem_we, 1'b0);
         tick();
      end
      rsp_ready = 2'b01;
      smp();
      chk("bp_ready_cycle_valid", rsp_valid, 2'b01);
      chk("bp_ready_cycle_no_grant", req_ready, 2'b00);
      tick();
      rsp_ready = 2'b00;
      smp();
      chk("bp_released", rsp_valid, 2'b00);
      chk("bp_grant1_after", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      smp();
      chk("bp_rsp1_valid", rsp_valid, 2'b10);
      chk("bp_rsp1_rdata", rsp_rdata, 32'h1234_5678);
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;

      // Port 0 grant moves priority to port 1, then reset during its response
      req_valid = 2'b01;
      smp();
      chk("mr_grant0", req_ready, 2'b01);
      tick();
      req_valid = 2'b11;
      smp();
      chk("mr_rsp_valid", rsp_valid, 2'b01);
      #1;
      rst = 1'b1;
      #1;
      chk("mr_rsp_dropped", rsp_valid, 2'b00);
      chk("mr_rdata_cleared", rsp_rdata, 32'h0);
      chk("mr_no_ready", req_ready, 2'b00);
      chk("mr_no_we", mem_we, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      rsp_ready = 2'b11;

      // Both ports held valid: port 0 first, then strict alternation
      for (int i = 0; i < 4; i++) begin
         got = 0;
         k = 0;
         while (!got && k < 4) begin
            smp();
            if (req_ready != 2'b00) got = 1;
            else tick();
            k++;
         end
         chk("alt_grant", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
         tick();
         smp();
         chk("alt_rsp_valid", rsp_valid, (i % 2 == 1) ? 2'b10 : 2'b01);
         chk("alt_rdata", rsp_rdata, (i % 2 == 1) ? 32'h1234_5678 : 32'hDEAD_BEEF);
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;

      // Randomized run against a transaction-level model
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < RS; i++) ref_mem[i] = tb_mem[i];
      m_resp = 0;
      m_pri = 0;
      m_pend = 0;
      m_rdata = '0;
      m_err = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         req_valid = 2'($urandom);
         req_we = 2'($urandom);
         rsp_ready = 2'($urandom);
         for (int p = 0; p < 2; p++) begin
            req_addr[p] = ($urandom_range(0, 9) == 0) ? AW'(RS + $urandom_range(0, 40))
                                                      : AW'($urandom_range(0, 15));
            req_wdata[p] = $urandom;
         end
         smp();
         if (m_resp) exp_rdy = 2'b00;
         else if (req_valid == 2'b11) exp_rdy = m_pri ? 2'b10 : 2'b01;
         else exp_rdy = req_valid;
         chk("rnd_req_ready", req_ready, exp_rdy);
         chk("rnd_rsp_valid", rsp_valid, m_resp ? (2'b01 << m_pend) : 2'b00);
         if (m_resp) begin
            chk("rnd_rdata", rsp_rdata, m_rdata);
            chk("rnd_err", rsp_err, m_err);
         end
         if (exp_rdy != 2'b00) begin
            g = exp_rdy[1] ? 1 : 0;
            inr = req_addr[g] < AW'(RS);
            chk("rnd_mem_we", mem_we, req_we[g] && inr);
            chk("rnd_mem_a", mem_a, req_addr[g]);
            if (req_we[g] && inr) begin
               ref_mem[req_addr[g][9:0]] = req_wdata[g];
               m_rdata = '0;
            end else if (!req_we[g] && inr) begin
               m_rdata = ref_mem[req_addr[g][9:0]];
            end else begin
               m_rdata = '0;
            end
            m_err = !inr;
            m_pri = (g == 0);
            m_pend = g;
            m_resp = 1;
         end else begin
            chk("rnd_mem_we_idle", mem_we, 1'b0);
            if (m_resp && rsp_ready[m_pend]) m_resp = 0;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/kamacore_mem_arbiter.md
Name: kamacore_mem_arbiter

Overview:
- Shares the single read/write port (we/a/di/spo) of the core memory between two requesters.
  - Port 0: core load/store unit.
  - Port 1: program loader/debug.
- Instruction fetch keeps the independent dual-port read path and is not routed through this block.
- Performs round-robin arbitration, valid/ready request and response handshakes, out-of-range address checking and response buffering with backpressure.

Parameters:
- MEM_ADDR_WIDTH, default ADDR_WIDTH: address width of requesters and memory.
- RAM_SIZE, default 1024: number of implemented words. Addresses >= RAM_SIZE are errors.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  [1:0]  per-port request valid.
- req_ready  output  [1:0]  per-port grant; handshake when valid & ready.
- req_we  input  [1:0]  per-port write (1) / read (0).
- req_addr  input  [1:0][MEM_ADDR_WIDTH-1:0]  per-port word address.
- req_wdata  input  [1:0][CPU_WIDTH-1:0]  per-port write data.
- rsp_valid  output  [1:0]  response valid, one-hot to the granted port.
- rsp_ready  input  [1:0]  per-port response accept.
- rsp_rdata  output  CPU_WIDTH  read data (0 for writes and errors).
- rsp_err  output  1  address was out of range; qualified by rsp_valid.
- mem_we  output  1  memory write enable.
- mem_a  output  MEM_ADDR_WIDTH  memory address.
- mem_di  output  CPU_WIDTH  memory write data.
- mem_spo  input  CPU_WIDTH  memory asynchronous read data for mem_a.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, priority pointer=port 0.
  - req_ready=0 and mem_we=0 while rst is high.
- FSM has two states:
  - IDLE: arbitrate among req_valid. At most one req_ready bit is high, and only in IDLE.
  - RESP: hold the registered response until the addressed port's rsp_ready=1, then return to IDLE.
- Arbitration:
  - One valid requester: grant it.
  - Both valid: grant the port named by the priority pointer.
  - After every grant, the pointer moves to the non-granted port.
  - req_ready is combinational from req_valid and state. Requesters must not make valid depend on ready.
- Grant cycle (IDLE, valid&ready):
  - mem_a and mem_di are driven from the granted port.
  - mem_we = granted req_we AND addr < RAM_SIZE.
  - mem_spo is captured into rsp_rdata at the clock edge (reads only; writes capture 0).
  - rsp_err captures (addr >= RAM_SIZE). Out-of-range reads return rsp_rdata=0.
  - Next cycle: state=RESP, rsp_valid one-hot to the granted port.
- Idle memory outputs: when no grant, mem_we=0, and mem_a/mem_di hold the port 0 values (don't care).
- Latency and throughput:
  - Response appears 1 cycle after the grant.
  - Maximum throughput is one transaction per 2 cycles.
  - No grant is issued in RESP, even on the rsp_ready cycle.
- Response backpressure: rsp_valid, rsp_rdata and rsp_err stay stable while rsp_ready=0. rsp_ready of the non-addressed port is ignored.
- Write semantics: a write commits exactly once, at the grant edge. No memory access occurs in RESP.
- Reset mid-operation: a pending response is dropped, no write is issued, and the pointer returns to port 0.
- Fairness: with both ports continuously valid, grants strictly alternate.

Optional Feature:
- Macro: KAMACORE_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants [1:0][31:0]: per-port grant counters.
  - Adds output stat_conflicts [31:0]: count of grant cycles with both ports valid.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- kamacore_pkg holds:
  - Existing ADDR_WIDTH and CPU_WIDTH.
  - arb_state_t enum {ARB_IDLE, ARB_RESP}.
  - Constants ARB_PORT_LSU=0 and ARB_PORT_LOADER=1.
- Sub-module kamacore_rr_arbiter2:
  - Inputs: valid[1:0], advance.
  - Output: one-hot grant[1:0].
  - Owns the priority pointer.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst 3 cycles, then release with no requests.
  - Required: rsp_valid=0, req_ready=0, mem_we=0 throughout.
- Port 0 write then read:
  - Stimulus: write addr 5 data 0xDEADBEEF, then read addr 5.
  - Required: mem_we=1 for exactly one cycle; read response rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after grant.
- Simultaneous requests, both ports held valid for 4 transactions:
  - Required: grants alternate 0,1,0,1.
  - Required: rsp_valid one-hot matches the granted port each time.
- Out-of-range write:
  - Stimulus: port 1 writes addr 1024 with RAM_SIZE=1024.
  - Required: mem_we stays 0; response has rsp_err=1, rsp_rdata=0.
- Backpressure:
  - Stimulus: port 0 reads with rsp_ready=0 for 5 cycles while port 1 is valid.
  - Required: response stable, no grant to port 1 until the cycle after rsp_ready=1.
- Reset mid-RESP:
  - Stimulus: assert rst while rsp_valid=1.
  - Required: rsp_valid drops immediately; after release, port 0 wins the first contested grant.
